// File: rtl/byte_window_shifter.sv
// byte_window_shifter: builds a sliding 32-bit window over the received
// byte stream and tracks frame offset, length and frame status.
module byte_window_shifter #(
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int OFFSET_W        = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  input  logic                sof,
  input  logic                eof,
  output logic [31:0]         window,
  output logic                window_valid,
  output logic [OFFSET_W-1:0] byte_offset,
  output logic                frame_active,
  output logic                frame_done,
  output logic [OFFSET_W-1:0] frame_len,
  output logic                runt_err,
  output logic                frame_abort
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DROP
  } state_t;

  localparam logic [OFFSET_W-1:0] ONE_C  = OFFSET_W'(1);
  localparam logic [OFFSET_W-1:0] FOUR_C = OFFSET_W'(4);
  localparam logic [OFFSET_W-1:0] MAX_C  = OFFSET_W'(MAX_FRAME_BYTES);
  localparam logic [OFFSET_W-1:0] MIN_C  = OFFSET_W'(MIN_FRAME_BYTES);
  localparam logic [OFFSET_W-1:0] SAT_C  = OFFSET_W'(MAX_FRAME_BYTES + 1);

  state_t              state;
  state_t              state_n;
  logic [OFFSET_W-1:0] count;
  logic [OFFSET_W-1:0] count_n;
  logic [OFFSET_W-1:0] cnt_inc;
  logic [31:0]         window_n;
  logic [OFFSET_W-1:0] offset_n;
  logic [OFFSET_W-1:0] len_n;
  logic                wv_n;
  logic                done_n;
  logic                runt_n;
  logic                abort_n;
  logic                active_n;
  logic                in_frame;
  logic                take_sof;
  logic                take_frm;
  logic                take_drop;

  assign in_frame  = (state == FILL) || (state == STREAM);
  assign take_sof  = byte_valid && sof;
  assign take_frm  = byte_valid && !sof && in_frame;
  assign take_drop = byte_valid && !sof && (state == DROP);
  assign cnt_inc   = (count == SAT_C) ? count : count + ONE_C;
  assign active_n  = (state_n == FILL) || (state_n == STREAM);

  // Next-state decode for one accepted (or idle) cycle.
  always_comb begin
    state_n  = state;
    count_n  = count;
    window_n = window;
    offset_n = byte_offset;
    len_n    = frame_len;
    wv_n     = 1'b0;
    done_n   = 1'b0;
    runt_n   = 1'b0;
    abort_n  = 1'b0;
    unique case (1'b1)
      take_sof: begin
        abort_n  = in_frame;
        window_n = {24'h0, byte_in};
        count_n  = ONE_C;
        if (eof) begin
          state_n = IDLE;
          done_n  = 1'b1;
          len_n   = ONE_C;
          runt_n  = (ONE_C < MIN_C);
        end else begin
          state_n = FILL;
        end
      end
      take_frm: begin
        if (cnt_inc > MAX_C) begin
          abort_n = 1'b1;
          count_n = SAT_C;
          state_n = eof ? IDLE : DROP;
        end else begin
          window_n = {window[23:0], byte_in};
          count_n  = cnt_inc;
          if (cnt_inc >= FOUR_C) begin
            wv_n     = 1'b1;
            offset_n = cnt_inc - FOUR_C;
            state_n  = STREAM;
          end else begin
            state_n  = FILL;
          end
          if (eof) begin
            state_n = IDLE;
            done_n  = 1'b1;
            len_n   = cnt_inc;
            runt_n  = (cnt_inc < MIN_C);
          end
        end
      end
      take_drop: begin
        if (eof) begin
          state_n = IDLE;
        end
      end
      default: begin
      end
    endcase
  end

  // State, window and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      window       <= '0;
      byte_offset  <= '0;
      frame_len    <= '0;
      window_valid <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      runt_err     <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      window       <= window_n;
      byte_offset  <= offset_n;
      frame_len    <= len_n;
      window_valid <= wv_n;
      frame_active <= active_n;
      frame_done   <= done_n;
      runt_err     <= runt_n;
      frame_abort  <= abort_n;
    end
  end

endmodule

// File: tb/tb_byte_window_shifter.sv
// tb_byte_window_shifter: scoreboard bench for byte_window_shifter.
// Expected windows and frame results are queued as bytes are driven.
module tb_byte_window_shifter;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        sof;
  logic        eof;
  logic [31:0] window;
  logic        window_valid;
  logic [10:0] byte_offset;
  logic        frame_active;
  logic        frame_done;
  logic [10:0] frame_len;
  logic        runt_err;
  logic        frame_abort;

  int n_checks;
  int n_fail;
  int n_abort;

  logic [42:0] exp_w[$];
  logic [42:0] obs_w[$];
  logic [11:0] exp_d[$];
  logic [11:0] obs_d[$];
  logic [42:0] ew;
  logic [42:0] ow;
  logic [11:0] ed;
  logic [11:0] od;

  byte_window_shifter dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .sof          (sof),
    .eof          (eof),
    .window       (window),
    .window_valid (window_valid),
    .byte_offset  (byte_offset),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .frame_len    (frame_len),
    .runt_err     (runt_err),
    .frame_abort  (frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs settle on posedge; record them mid-cycle.
  always @(negedge clk) begin
    if (window_valid === 1'b1) obs_w.push_back({window, byte_offset});
    if (frame_done === 1'b1) obs_d.push_back({frame_len, runt_err});
    if (frame_abort === 1'b1) n_abort++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  task automatic drive(input logic [7:0] b, input logic s,
                       input logic e, input int gap);
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      sof        = 1'($urandom);
      eof        = 1'($urandom);
    end
    @(negedge clk);
    byte_in    = b;
    sof        = s;
    eof        = e;
    byte_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0;
      sof        = 1'b0;
      eof        = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] first, input logic [7:0] step,
                            input int n, input int gap_max,
                            input logic with_eof);
    logic [31:0] w;
    logic [7:0]  b;
    int          g;
    w = '0;
    b = first;
    for (int i = 1; i <= n; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      drive(b, i == 1, with_eof && (i == n), g);
      w = {w[23:0], b};
      if (i >= 4) exp_w.push_back({w, 11'(i - 4)});
      b = b + step;
    end
    if (with_eof) exp_d.push_back({11'(n), n < 64});
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      byte_in    = 8'($urandom);
      byte_valid = 1'($urandom);
      sof        = 1'($urandom);
      eof        = 1'($urandom);
    end
    @(negedge clk);
    n_checks += 8;
    if (window !== 32'h0) begin n_fail++;
      $display("FAIL rst_window got %h want 0", window); end
    if (window_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_wv got %b want 0", window_valid); end
    if (byte_offset !== 11'd0) begin n_fail++;
      $display("FAIL rst_offset got %0d want 0", byte_offset); end
    if (frame_active !== 1'b0) begin n_fail++;
      $display("FAIL rst_active got %b want 0", frame_active); end
    if (frame_done !== 1'b0) begin n_fail++;
      $display("FAIL rst_done got %b want 0", frame_done); end
    if (frame_len !== 11'd0) begin n_fail++;
      $display("FAIL rst_len got %0d want 0", frame_len); end
    if (runt_err !== 1'b0) begin n_fail++;
      $display("FAIL rst_runt got %b want 0", runt_err); end
    if (frame_abort !== 1'b0) begin n_fail++;
      $display("FAIL rst_abort got %b want 0", frame_abort); end
    rst = 1'b0;
    idle(1);
    obs_w.delete();
    obs_d.delete();
    n_abort = 0;
    send_frame(8'h11, 8'h11, 5, 0, 1'b0);
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'($urandom);
    sof        = 1'($urandom);
    eof        = 1'($urandom);
    @(negedge clk);
    n_checks += 3;
    if (frame_active !== 1'b0) begin n_fail++;
      $display("FAIL midrst_active got %b want 0", frame_active); end
    if (window !== 32'h0) begin n_fail++;
      $display("FAIL midrst_window got %h want 0", window); end
    if (window_valid !== 1'b0) begin n_fail++;
      $display("FAIL midrst_wv got %b want 0", window_valid); end
    rst = 1'b0;
    idle(2);
    while (exp_w.size() > 0) begin
      ew = exp_w.pop_front();
      if (obs_w.size() > 0) ow = obs_w.pop_front(); else ow = 'x;
      n_checks++;
      if (ow !== ew) begin n_fail++;
        $display("FAIL midrst_win got %h/%0d want %h/%0d",
                 ow[42:11], ow[10:0], ew[42:11], ew[10:0]); end
    end
    n_checks += 2;
    if (obs_w.size() != 0) begin n_fail++;
      $display("FAIL midrst_extra_win got %0d want 0", obs_w.size()); end
    if (obs_d.size() != 0) begin n_fail++;
      $display("FAIL midrst_done got %0d want 0", obs_d.size()); end
    obs_w.delete();
    obs_d.delete();
  endtask

  task automatic test_frame64;
    n_abort = 0;
    send_frame(8'h01, 8'h01, 64, 0, 1'b1);
    idle(3);
    n_checks += 3;
    if (obs_w.size() == 0 || obs_w[0] !== {32'h01020304, 11'd0}) begin
      n_fail++;
      $display("FAIL f64_first got %h want 01020304/0", obs_w[0]); end
    if (obs_w.size() == 0 || obs_w[$] !== {32'h3D3E3F40, 11'd60}) begin
      n_fail++;
      $display("FAIL f64_last got %h want 3d3e3f40/60", obs_w[$]); end
    if (frame_active !== 1'b0) begin n_fail++;
      $display("FAIL f64_active got %b want 0", frame_active); end
    while (exp_w.size() > 0) begin
      ew = exp_w.pop_front();
      if (obs_w.size() > 0) ow = obs_w.pop_front(); else ow = 'x;
      n_checks++;
      if (ow !== ew) begin n_fail++;
        $display("FAIL f64_win got %h/%0d want %h/%0d",
                 ow[42:11], ow[10:0], ew[42:11], ew[10:0]); end
    end
    while (exp_d.size() > 0) begin
      ed = exp_d.pop_front();
      if (obs_d.size() > 0) od = obs_d.pop_front(); else od = 'x;
      n_checks++;
      if (od !== ed) begin n_fail++;
        $display("FAIL f64_done got len %0d runt %b want len %0d runt %b",
                 od[11:1], od[0], ed[11:1], ed[0]); end
    end
    n_checks += 3;
    if (obs_w.size() != 0) begin n_fail++;
      $display("FAIL f64_extra_win got %0d want 0", obs_w.size()); end
    if (obs_d.size() != 0) begin n_fail++;
      $display("FAIL f64_extra_done got %0d want 0", obs_d.size()); end
    if (n_abort != 0) begin n_fail++;
      $display("FAIL f64_abort got %0d want 0", n_abort); end
    obs_w.delete();
    obs_d.delete();
  endtask

  task automatic test_runt;
    n_abort = 0;
    send_frame(8'hAA, 8'h11, 3, 0, 1'b1);
    idle(2);
    n_checks++;
    if (window !== 32'h00AABBCC) begin n_fail++;
      $display("FAIL runt_window got %h want 00aabbcc", window); end
    send_frame(8'h5A, 8'h00, 1, 0, 1'b1);
    idle(3);
    while (exp_d.size() > 0) begin
      ed = exp_d.pop_front();
      if (obs_d.size() > 0) od = obs_d.pop_front(); else od = 'x;
      n_checks++;
      if (od !== ed) begin n_fail++;
        $display("FAIL runt_done got len %0d runt %b want len %0d runt %b",
                 od[11:1], od[0], ed[11:1], ed[0]); end
    end
    n_checks += 3;
    if (obs_w.size() != 0) begin n_fail++;
      $display("FAIL runt_win got %0d want 0", obs_w.size()); end
    if (obs_d.size() != 0) begin n_fail++;
      $display("FAIL runt_extra_done got %0d want 0", obs_d.size()); end
    if (n_abort != 0) begin n_fail++;
      $display("FAIL runt_abort got %0d want 0", n_abort); end
    exp_w.delete();
    obs_w.delete();
    obs_d.delete();
  endtask

  task automatic test_abort;
    n_abort = 0;
    send_frame(8'h10, 8'h01, 10, 0, 1'b0);
    idle(1);
    n_checks++;
    if (frame_active !== 1'b1) begin n_fail++;
      $display("FAIL abort_active got %b want 1", frame_active); end
    send_frame(8'h55, 8'h11, 4, 0, 1'b1);
    idle(3);
    n_checks += 2;
    if (n_abort != 1) begin n_fail++;
      $display("FAIL abort_count got %0d want 1", n_abort); end
    if (obs_w.size() == 0 || obs_w[$] !== {32'h55667788, 11'd0}) begin
      n_fail++;
      $display("FAIL abort_newwin got %h want 55667788/0", obs_w[$]); end
    while (exp_w.size() > 0) begin
      ew = exp_w.pop_front();
      if (obs_w.size() > 0) ow = obs_w.pop_front(); else ow = 'x;
      n_checks++;
      if (ow !== ew) begin n_fail++;
        $display("FAIL abort_win got %h/%0d want %h/%0d",
                 ow[42:11], ow[10:0], ew[42:11], ew[10:0]); end
    end
    while (exp_d.size() > 0) begin
      ed = exp_d.pop_front();
      if (obs_d.size() > 0) od = obs_d.pop_front(); else od = 'x;
      n_checks++;
      if (od !== ed) begin n_fail++;
        $display("FAIL abort_done got len %0d runt %b want len %0d runt %b",
                 od[11:1], od[0], ed[11:1], ed[0]); end
    end
    n_checks += 2;
    if (obs_w.size() != 0) begin n_fail++;
      $display("FAIL abort_extra_win got %0d want 0", obs_w.size()); end
    if (obs_d.size() != 0) begin n_fail++;
      $display("FAIL abort_extra_done got %0d want 0", obs_d.size()); end
    obs_w.delete();
    obs_d.delete();
  endtask

  task automatic test_oversize;
    n_abort = 0;
    send_frame(8'h00, 8'h01, 1518, 0, 1'b0);
    drive(8'hEE, 1'b0, 1'b0, 0);
    idle(2);
    n_checks += 2;
    if (n_abort != 1) begin n_fail++;
      $display("FAIL over_abort got %0d want 1", n_abort); end
    if (frame_active !== 1'b0) begin n_fail++;
      $display("FAIL over_active got %b want 0", frame_active); end
    for (int i = 0; i < 4; i++) drive(8'(i), 1'b0, i == 3, 1);
    idle(2);
    n_checks++;
    if (frame_active !== 1'b0) begin n_fail++;
      $display("FAIL drop_active got %b want 0", frame_active); end
    send_frame(8'hC0, 8'h01, 8, 0, 1'b1);
    idle(3);
    n_checks++;
    if (n_abort != 1) begin n_fail++;
      $display("FAIL over_abort2 got %0d want 1", n_abort); end
    while (exp_w.size() > 0) begin
      ew = exp_w.pop_front();
      if (obs_w.size() > 0) ow = obs_w.pop_front(); else ow = 'x;
      n_checks++;
      if (ow !== ew) begin n_fail++;
        $display("FAIL over_win got %h/%0d want %h/%0d",
                 ow[42:11], ow[10:0], ew[42:11], ew[10:0]); end
    end
    while (exp_d.size() > 0) begin
      ed = exp_d.pop_front();
      if (obs_d.size() > 0) od = obs_d.pop_front(); else od = 'x;
      n_checks++;
      if (od !== ed) begin n_fail++;
        $display("FAIL over_done got len %0d runt %b want len %0d runt %b",
                 od[11:1], od[0], ed[11:1], ed[0]); end
    end
    n_checks += 2;
    if (obs_w.size() != 0) begin n_fail++;
      $display("FAIL over_extra_win got %0d want 0", obs_w.size()); end
    if (obs_d.size() != 0) begin n_fail++;
      $display("FAIL over_extra_done got %0d want 0", obs_d.size()); end
    obs_w.delete();
    obs_d.delete();
  endtask

  task automatic test_max_frame;
    n_abort = 0;
    send_frame(8'h80, 8'h03, 1518, 0, 1'b1);
    idle(3);
    n_checks++;
    if (n_abort != 0) begin n_fail++;
      $display("FAIL max_abort got %0d want 0", n_abort); end
    while (exp_w.size() > 0) begin
      ew = exp_w.pop_front();
      if (obs_w.size() > 0) ow = obs_w.pop_front(); else ow = 'x;
      n_checks++;
      if (ow !== ew) begin n_fail++;
        $display("FAIL max_win got %h/%0d want %h/%0d",
                 ow[42:11], ow[10:0], ew[42:11], ew[10:0]); end
    end
    while (exp_d.size() > 0) begin
      ed = exp_d.pop_front();
      if (obs_d.size() > 0) od = obs_d.pop_front(); else od = 'x;
      n_checks++;
      if (od !== ed) begin n_fail++;
        $display("FAIL max_done got len %0d runt %b want len %0d runt %b",
                 od[11:1], od[0], ed[11:1], ed[0]); end
    end
    n_checks += 2;
    if (obs_w.size() != 0) begin n_fail++;
      $display("FAIL max_extra_win got %0d want 0", obs_w.size()); end
    if (obs_d.size() != 0) begin n_fail++;
      $display("FAIL max_extra_done got %0d want 0", obs_d.size()); end
    obs_w.delete();
    obs_d.delete();
  endtask

  task automatic test_gaps;
    n_abort = 0;
    for (int i = 0; i < 3; i++) drive(8'hF0 + 8'(i), 1'b0, 1'b0, 1);
    idle(2);
    n_checks += 2;
    if (obs_w.size() != 0) begin n_fail++;
      $display("FAIL idle_win got %0d want 0", obs_w.size()); end
    if (frame_active !== 1'b0) begin n_fail++;
      $display("FAIL idle_active got %b want 0", frame_active); end
    send_frame(8'hA0, 8'h07, 20, 3, 1'b1);
    idle(3);
    while (exp_w.size() > 0) begin
      ew = exp_w.pop_front();
      if (obs_w.size() > 0) ow = obs_w.pop_front(); else ow = 'x;
      n_checks++;
      if (ow !== ew) begin n_fail++;
        $display("FAIL gap_win got %h/%0d want %h/%0d",
                 ow[42:11], ow[10:0], ew[42:11], ew[10:0]); end
    end
    while (exp_d.size() > 0) begin
      ed = exp_d.pop_front();
      if (obs_d.size() > 0) od = obs_d.pop_front(); else od = 'x;
      n_checks++;
      if (od !== ed) begin n_fail++;
        $display("FAIL gap_done got len %0d runt %b want len %0d runt %b",
                 od[11:1], od[0], ed[11:1], ed[0]); end
    end
    n_checks += 3;
    if (obs_w.size() != 0) begin n_fail++;
      $display("FAIL gap_extra_win got %0d want 0", obs_w.size()); end
    if (obs_d.size() != 0) begin n_fail++;
      $display("FAIL gap_extra_done got %0d want 0", obs_d.size()); end
    if (n_abort != 0) begin n_fail++;
      $display("FAIL gap_abort got %0d want 0", n_abort); end
    obs_w.delete();
    obs_d.delete();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    n_abort    = 0;
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    sof        = 1'b0;
    eof        = 1'b0;
    test_reset();
    test_frame64();
    test_runt();
    test_abort();
    test_oversize();
    test_max_frame();
    test_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
